// File: rtl/pipeline_ctrl.sv
// Pipeline stage-enable and flush controller: redirect sequencing, stall watchdog, perf counters.
// Optional perf counters are enabled by defining PIPE_PERF_CNT_EN.
module pipeline_ctrl #(
  parameter int unsigned BR_FLUSH_CYCLES = 1,
  parameter int unsigned MAX_STALL       = 16,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hz_stall,
  input  logic             hz_flush_id_ex,
  input  logic             br_taken,
  input  logic             dmem_busy,
  output logic             pc_we,
  output logic             pc_sel_br,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_we,
  output logic             id_ex_flush,
  output logic             ex_mem_we,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {StRun, StRedirect, StFreeze} state_e;

  localparam logic [1:0] BrFlushLeft = 2'(BR_FLUSH_CYCLES - 1);
  localparam logic [7:0] MaxStall    = 8'(MAX_STALL);

  state_e     state_q, state_d;
  logic [1:0] flush_left_q, flush_left_d;
  logic       ret_redirect_q, ret_redirect_d;
  logic [7:0] stall_run_q, stall_run_d;
  logic       timeout_q, timeout_d;
  logic       in_redirect;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StRun;
      flush_left_q   <= 2'd0;
      ret_redirect_q <= 1'b0;
      stall_run_q    <= 8'd0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      flush_left_q   <= flush_left_d;
      ret_redirect_q <= ret_redirect_d;
      stall_run_q    <= stall_run_d;
      timeout_q      <= timeout_d;
    end
  end

  always_comb begin
    pc_we          = 1'b1;
    pc_sel_br      = 1'b0;
    if_id_we       = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_we       = 1'b1;
    id_ex_flush    = 1'b0;
    ex_mem_we      = 1'b1;
    state_d        = state_q;
    flush_left_d   = flush_left_q;
    ret_redirect_d = ret_redirect_q;
    stall_run_d    = stall_run_q;
    timeout_d      = timeout_q | (stall_run_q >= MaxStall);
    in_redirect    = 1'b0;

    if (!rst_n) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_we    = 1'b0;
      id_ex_flush = 1'b1;
      ex_mem_we   = 1'b0;
    end else if (dmem_busy) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_we  = 1'b0;
      ex_mem_we = 1'b0;
      if (state_q != StFreeze) begin
        state_d        = StFreeze;
        ret_redirect_d = (state_q == StRedirect);
      end
    end else begin
      // The freeze-release cycle behaves as RUN; the redirect remainder resumes next cycle.
      if (state_q == StFreeze) begin
        state_d = ret_redirect_q ? StRedirect : StRun;
      end else begin
        in_redirect = (state_q == StRedirect);
      end

      if (hz_stall) begin
        stall_run_d = (stall_run_q == 8'hff) ? stall_run_q : stall_run_q + 8'd1;
      end else begin
        stall_run_d = 8'd0;
      end

      id_ex_flush = hz_flush_id_ex;

      if (hz_stall) begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_flush = 1'b1;
      end else if (br_taken && !in_redirect) begin
        pc_sel_br   = 1'b1;
        if_id_flush = 1'b1;
        if (BR_FLUSH_CYCLES > 1) begin
          flush_left_d = BrFlushLeft;
          state_d      = StRedirect;
        end else begin
          state_d = StRun;
        end
      end else if (in_redirect) begin
        if_id_flush  = 1'b1;
        flush_left_d = flush_left_q - 2'd1;
        if (flush_left_q <= 2'd1) begin
          flush_left_d = 2'd0;
          state_d      = StRun;
        end
      end
    end
  end

  assign stall_timeout = timeout_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_inc, flush_inc;

  assign stall_inc = rst_n & ~dmem_busy & hz_stall;
  assign flush_inc = rst_n & if_id_flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: vector table plus redirect/freeze, reset and watchdog sequences.
module tb_pipeline_ctrl;
  logic clk = 1'b0;
  logic rst_n, hz_stall, hz_flush_id_ex, br_taken, dmem_busy;

  logic a_pc_we, a_pc_sel_br, a_if_id_we, a_if_id_flush, a_id_ex_we, a_id_ex_flush;
  logic a_ex_mem_we, a_stall_timeout;
  logic [31:0] a_stall_cnt, a_flush_cnt;
  logic b_pc_we, b_pc_sel_br, b_if_id_we, b_if_id_flush, b_id_ex_we, b_id_ex_flush;
  logic b_ex_mem_we, b_stall_timeout;
  logic [31:0] b_stall_cnt, b_flush_cnt;

  logic [7:0] ctl_a, ctl_b;
  assign ctl_a = {a_pc_we, a_pc_sel_br, a_if_id_we, a_if_id_flush,
                  a_id_ex_we, a_id_ex_flush, a_ex_mem_we, a_stall_timeout};
  assign ctl_b = {b_pc_we, b_pc_sel_br, b_if_id_we, b_if_id_flush,
                  b_id_ex_we, b_id_ex_flush, b_ex_mem_we, b_stall_timeout};

  pipeline_ctrl #(.BR_FLUSH_CYCLES(2), .MAX_STALL(4), .CNT_W(32)) u_a (
    .clk(clk), .rst_n(rst_n), .hz_stall(hz_stall), .hz_flush_id_ex(hz_flush_id_ex),
    .br_taken(br_taken), .dmem_busy(dmem_busy), .pc_we(a_pc_we), .pc_sel_br(a_pc_sel_br),
    .if_id_we(a_if_id_we), .if_id_flush(a_if_id_flush), .id_ex_we(a_id_ex_we),
    .id_ex_flush(a_id_ex_flush), .ex_mem_we(a_ex_mem_we), .stall_timeout(a_stall_timeout),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  pipeline_ctrl #(.BR_FLUSH_CYCLES(3), .MAX_STALL(16), .CNT_W(32)) u_b (
    .clk(clk), .rst_n(rst_n), .hz_stall(hz_stall), .hz_flush_id_ex(hz_flush_id_ex),
    .br_taken(br_taken), .dmem_busy(dmem_busy), .pc_we(b_pc_we), .pc_sel_br(b_pc_sel_br),
    .if_id_we(b_if_id_we), .if_id_flush(b_if_id_flush), .id_ex_we(b_id_ex_we),
    .id_ex_flush(b_id_ex_flush), .ex_mem_we(b_ex_mem_we), .stall_timeout(b_stall_timeout),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst_n;
    logic       stall;
    logic       fl;
    logic       br;
    logic       busy;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[18];

  localparam logic [7:0] CtlRst   = 8'b0001_0100;
  localparam logic [7:0] CtlIdle  = 8'b1010_1010;
  localparam logic [7:0] CtlStall = 8'b0000_1110;
  localparam logic [7:0] CtlHzFl  = 8'b1010_1110;
  localparam logic [7:0] CtlBr    = 8'b1111_1010;
  localparam logic [7:0] CtlRedir = 8'b1011_1010;
  localparam logic [7:0] CtlBusy  = 8'b0000_0000;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drive inputs just after a rising edge, then wait for the falling edge to sample.
  task automatic drive(input logic r, input logic s, input logic f, input logic b,
                       input logic m);
    rst_n = r; hz_stall = s; hz_flush_id_ex = f; br_taken = b; dmem_busy = m;
    @(negedge clk);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CtlRst};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CtlIdle};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CtlIdle};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CtlIdle};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, CtlStall};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, CtlStall};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, CtlHzFl};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, CtlBr};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CtlRedir};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CtlIdle};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, CtlStall};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, CtlBusy};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CtlIdle};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, CtlBr};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, CtlRedir};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CtlIdle};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, CtlBusy};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CtlIdle};

    do_reset();
    do_reset();

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].rst_n, vecs[i].stall, vecs[i].fl, vecs[i].br, vecs[i].busy);
      chk($sformatf("vec%0d", i), {24'd0, ctl_a}, {24'd0, vecs[i].exp});
      tick();
    end

    // Performance counters: two stall cycles, then a two-cycle branch flush.
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_PERF_CNT_EN
    chk("stall_cnt", a_stall_cnt, 32'd2);
    chk("flush_cnt", a_flush_cnt, 32'd2);
`else
    chk("stall_cnt_tied", a_stall_cnt, 32'd0);
    chk("flush_cnt_tied", a_flush_cnt, 32'd0);
`endif
    tick();

    // Three-cycle redirect interrupted by a four-cycle freeze.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("b_br", {24'd0, ctl_b}, {24'd0, CtlBr});
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      chk($sformatf("b_busy%0d", i), {24'd0, ctl_b}, {24'd0, CtlBusy});
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b_release", {24'd0, ctl_b}, {24'd0, CtlIdle});
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("b_resume%0d", i), {24'd0, ctl_b}, {24'd0, CtlRedir});
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b_done", {24'd0, ctl_b}, {24'd0, CtlIdle});
    tick();

    // Reset in the middle of a redirect abandons it.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b_rst_mid_redirect", {24'd0, ctl_b}, {24'd0, CtlIdle});
    tick();

    // Watchdog with MAX_STALL=4 on u_a, default 16 on u_b.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 3) chk("wd_early", {31'd0, a_stall_timeout}, 32'd0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wd_trip", {31'd0, a_stall_timeout}, 32'd1);
    chk("wd_b_quiet", {31'd0, b_stall_timeout}, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wd_sticky", {31'd0, a_stall_timeout}, 32'd1);
    tick();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wd_cleared", {31'd0, a_stall_timeout}, 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
